// File: rtl/core_decode_queue_if.sv
// Handshake bundle between fetch, the decode queue and execute.
// Latency: none; this is wiring only.
// Backpressure: in_ready gates fetch pushes and out_ready gates execute takes.
// Signals: in_valid/in_ready/in_instr/in_pc carry the fetch side.
//          out_valid/out_ready/out_instr/out_pc/out_phase/out_last/out_amo/out_illegal carry the execute side.
// The master modport is the environment around the queue; the slave modport is the queue itself.
interface core_decode_queue_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_instr;
  logic [PC_W-1:0] out_pc;
  logic            out_phase;
  logic            out_last;
  logic            out_amo;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_phase, out_last, out_amo, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_phase, out_last, out_amo, out_illegal
  );
endinterface

// File: rtl/core_decode_queue.sv
// Instruction buffer between fetch and execute that decodes the head entry and sequences two-phase AMOs.
// Latency: a pushed entry reaches out_* one cycle after the push at the earliest (no bypass).
// Backpressure: in_ready drops when full, during flush or during reset; the head holds while out_ready is low.
// Ports: clk, rst_n (synchronous, active-low), flush, bus (core_decode_queue_if.slave), count (occupancy).
// Build option: define CORE_DECODE_QUEUE_AMO_EN to enable the two-phase AMO sequencing; otherwise
// opcode 0101111 is reported illegal and out_amo/out_phase are tied to 0.
module core_decode_queue #(
  parameter int DEPTH = 2,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  core_decode_queue_if.slave           bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic        push;
  logic        take;
  logic        pop;
  logic [31:0] head_instr;
  logic [6:0]  opcode;
  logic        illegal;
  logic        amo;

  // Gating with rst_n keeps both handshakes quiet while reset is held,
  // whatever count happens to hold before the first reset edge.
  assign bus.in_ready  = (count != FULL) & ~flush & rst_n;
  assign bus.out_valid = (count != '0) & rst_n;

  assign push = bus.in_valid & bus.in_ready;
  assign take = bus.out_valid & bus.out_ready;

  assign head_instr    = mem_instr[rd_ptr];
  assign opcode        = head_instr[6:0];
  assign bus.out_instr = head_instr;
  assign bus.out_pc    = mem_pc[rd_ptr];

  always_comb begin
    illegal = 1'b1;
    case (opcode)
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
      7'b1101111, 7'b1100111, 7'b1100011, 7'b0000011,
      7'b0100011, 7'b1110011, 7'b0001111: illegal = 1'b0;
`ifdef CORE_DECODE_QUEUE_AMO_EN
      7'b0101111:                         illegal = 1'b0;
`endif
      default:                            illegal = 1'b1;
    endcase
  end

  assign bus.out_illegal = illegal;

`ifdef CORE_DECODE_QUEUE_AMO_EN
  typedef enum logic {PH0 = 1'b0, PH1 = 1'b1} phase_t;
  phase_t phase_q;
  phase_t phase_d;

  // LR and SC are single-access; every other A-extension op is read then write.
  assign amo = (opcode == 7'b0101111) & ~illegal &
               (head_instr[31:27] != 5'b00010) & (head_instr[31:27] != 5'b00011);

  always_comb begin
    phase_d = phase_q;
    pop     = 1'b0;
    if (take) begin
      if (phase_q == PH0 && amo) begin
        phase_d = PH1;
      end else begin
        phase_d = PH0;
        pop     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      phase_q <= PH0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign bus.out_phase = (phase_q == PH1);
`else
  assign amo           = 1'b0;
  assign pop           = take;
  assign bus.out_phase = 1'b0;
`endif

  assign bus.out_amo  = amo;
  assign bus.out_last = ~amo | bus.out_phase;

  // Storage is not reset: occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= bus.in_instr;
      mem_pc[wr_ptr]    <= bus.in_pc;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: doc/core_decode_queue.md
CORE_DECODE_QUEUE -- requirements
Module: core_decode_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2: instruction buffer entries; power of two, at least 2.
REQ-002 SHALL have parameter PC_W, default 32: program-counter width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port flush, input, 1: discard all buffered instructions.
REQ-006 SHALL have port in_valid, input, 1: fetch offers an instruction.
REQ-007 SHALL have port in_ready, output, 1: block accepts; push = in_valid & in_ready.
REQ-008 SHALL have ports in_instr (input, 32) and in_pc (input, PC_W): pushed instruction word and its PC.
REQ-009 SHALL have port out_valid, output, 1: a head-of-queue phase is presented.
REQ-010 SHALL have port out_ready, input, 1: execute accepts; take = out_valid & out_ready.
REQ-011 SHALL have ports out_instr (output, 32) and out_pc (output, PC_W): head entry contents.
REQ-012 SHALL have port out_phase, output, 1: current execution phase of the head entry (0 or 1).
REQ-013 SHALL have port out_last, output, 1: the presented phase is the final phase of the head entry.
REQ-014 SHALL have port out_amo, output, 1: the head entry is a two-phase read-modify-write AMO.
REQ-015 SHALL have port out_illegal, output, 1: the head entry's opcode is unsupported.
REQ-016 SHALL have port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-017 SHALL buffer entries in FIFO order in a circular buffer with wrap-around read and write pointers.
REQ-018 SHALL drive in_ready = (count != DEPTH) & ~flush; in_ready SHALL have no combinational path from out_ready.
REQ-019 SHALL, on push, make the entry visible on out_* no earlier than the following cycle (minimum latency 1, no bypass).
REQ-020 SHALL drive out_valid = (count != 0); out_* are don't-care when out_valid = 0.
REQ-021 SHALL set out_amo = 1 when opcode = 0101111 and instr[31:27] is neither 00010 (LR) nor 00011 (SC); all other entries are single-phase.
REQ-022 SHALL set out_illegal = 1 when opcode is none of 0110011, 0010011, 0110111, 0010111, 1101111, 1100111, 1100011, 0000011, 0100011, 0101111, 1110011, 0001111.
REQ-023 SHALL treat any entry with out_illegal = 1 as single-phase.
REQ-024 SHALL implement the phase FSM PH0/PH1, driving out_phase = 0 in PH0 and 1 in PH1.
REQ-025 SHALL move PH0 -> PH1 on take of an out_amo head, without popping the entry.
REQ-026 SHALL move PH1 -> PH0 on take, popping the entry.
REQ-027 SHALL stay in PH0 and pop on take of a single-phase head.
REQ-028 SHALL drive out_last = ~out_amo | out_phase.
REQ-029 SHALL hold the head entry stable while out_valid = 1 and out_ready = 0.
REQ-030 SHALL, when push and pop occur in the same cycle, leave count unchanged and advance both pointers.
REQ-031 SHALL, on flush, set count = 0, pointers = 0 and phase = PH0 in the next cycle, ignoring a same-cycle push or take; an AMO stopped in PH1 by flush is abandoned.

Reset
REQ-032 SHALL, while rst_n = 0 at a clock edge, clear count, pointers and phase to PH0.
REQ-033 SHALL force in_ready = 0 and out_valid = 0 while rst_n = 0.
REQ-034 SHALL present count = 0, out_valid = 0 and in_ready = 1 in the first cycle after rst_n rises.
REQ-035 SHALL discard buffer contents on reset, including a reset asserted mid-AMO.

Configuration
REQ-036 SHALL, with CORE_DECODE_QUEUE_AMO_EN defined, behave as REQ-021 to REQ-028.
REQ-037 SHALL, without CORE_DECODE_QUEUE_AMO_EN defined, tie out_amo = 0, tie out_phase = 0, omit the phase FSM, and add opcode 0101111 to the illegal set.

Verification
REQ-038 SHALL cover: DEPTH=2; push ADDI 0x00500093 at pc 0x100 with out_ready=1 -> out_valid next cycle, out_last=1, out_illegal=0, count returns to 0.
REQ-039 SHALL cover: push AMOADD.W 0x00B5202F, out_ready=1 -> two takes, out_phase 0 then 1, out_last 0 then 1; count 1 -> 0 only after the second take.
REQ-040 SHALL cover: out_ready=0 with 3 pushes offered -> count=2, in_ready=0 on the third; then a single-cycle take -> in_ready=1 the next cycle and FIFO order is preserved.
REQ-041 SHALL cover: flush while an AMO is in PH1 with count=2 and in_valid=1 -> next cycle count=0, out_valid=0, out_phase=0, the pushed word is dropped.
REQ-042 SHALL cover: push 0x0000007F -> out_illegal=1, single take pops; without the macro, 0x00B5202F -> out_illegal=1 and out_amo=0.
REQ-043 SHALL cover: rst_n=0 for one cycle mid-stream -> count=0 and in_ready=1 after release; 10 pushes with concurrent pops exercise pointer wrap.
